// File: rtl/move_ctrl.sv
// move_ctrl: consumer of the get_input stage.
// Requests a sample, waits for the done strobe (or times out), applies the
// latched right/left/reset command to a bounded position register, then
// holds for a fixed move tick before re-arming the request.
module move_ctrl #(
    parameter int POS_W    = 4,
    parameter int POS_MAX  = 15,
    parameter int POS_INIT = 7,
    parameter int WRAP     = 0,
    parameter int TICK_CYC = 4,
    parameter int TO_CYC   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    output logic             e_inp_o,
    input  logic             d_inp_i,
    input  logic             right_i,
    input  logic             left_i,
    input  logic             rst_cmd_i,
    output logic [POS_W-1:0] pos_o,
    output logic             moved_o,
    output logic             bump_o,
    output logic             timeout_o
);

    localparam int TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    localparam logic [POS_W-1:0]  P_MAX     = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]  P_INIT    = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0]  P_ONE     = POS_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_APPLY = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Command captured on the done strobe; get_input may change its
    // outputs right after, so APPLY works only from this copy.
    typedef struct packed {
        logic rst;
        logic right;
        logic left;
    } cmd_t;

    state_t            state;
    cmd_t              cmd_q;
    logic [TO_W-1:0]   to_cnt;
    logic [TICK_W-1:0] tick;

    logic [POS_W-1:0]  nxt_pos;
    logic              nxt_bump;

    // Next position from the latched command: reset command wins, opposing
    // directions cancel, and a step off either end wraps or is blocked.
    always_comb begin
        nxt_pos  = pos_o;
        nxt_bump = 1'b0;
        if (cmd_q.rst) begin
            nxt_pos = P_INIT;
        end else if (cmd_q.right && !cmd_q.left) begin
            if (pos_o == P_MAX) begin
                if (WRAP != 0) nxt_pos = '0;
                else           nxt_bump = 1'b1;
            end else begin
                nxt_pos = pos_o + P_ONE;
            end
        end else if (cmd_q.left && !cmd_q.right) begin
            if (pos_o == '0) begin
                if (WRAP != 0) nxt_pos = P_MAX;
                else           nxt_bump = 1'b1;
            end else begin
                nxt_pos = pos_o - P_ONE;
            end
        end
    end

    // Handshake / apply / hold sequencer; all outputs registered here and the
    // status pulses default low so each lives exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            to_cnt    <= '0;
            tick      <= '0;
            pos_o     <= P_INIT;
            e_inp_o   <= 1'b0;
            moved_o   <= 1'b0;
            bump_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            moved_o   <= 1'b0;
            bump_o    <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    e_inp_o <= 1'b0;
                    if (run_i) begin
                        state   <= S_WAIT;
                        e_inp_o <= 1'b1;
                        to_cnt  <= '0;
                    end
                end
                // run_i is deliberately ignored here: once requested, the
                // handshake is always closed out by done or by timeout.
                S_WAIT: begin
                    if (d_inp_i) begin
                        cmd_q.rst   <= rst_cmd_i;
                        cmd_q.right <= right_i;
                        cmd_q.left  <= left_i;
                        e_inp_o     <= 1'b0;
                        state       <= S_APPLY;
                    end else if (to_cnt == TO_LAST) begin
                        e_inp_o   <= 1'b0;
                        timeout_o <= 1'b1;
                        tick      <= TICK_LAST;
                        state     <= S_HOLD;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                S_APPLY: begin
                    pos_o   <= nxt_pos;
                    moved_o <= (nxt_pos != pos_o);
                    bump_o  <= nxt_bump;
                    tick    <= TICK_LAST;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (tick == '0) begin
                        if (run_i) begin
                            state   <= S_WAIT;
                            e_inp_o <= 1'b1;
                            to_cnt  <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        tick <= tick - TICK_ONE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    e_inp_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_ctrl.sv
// tb_move_ctrl: drives a clamping and a wrapping move_ctrl in lockstep with
// randomized handshakes and checks them against a transaction-level model.
module tb_move_ctrl;

    localparam int POS_W    = 4;
    localparam int POS_MAX  = 15;
    localparam int POS_INIT = 7;
    localparam int TICK_CYC = 4;
    localparam int TO_CYC   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, run, d_inp, right, left, rst_cmd;
    logic e0, e1, mv0, mv1, bp0, bp1, to0, to1;
    logic [POS_W-1:0] pos0, pos1;

    move_ctrl #(.POS_W(POS_W), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT), .WRAP(0),
                .TICK_CYC(TICK_CYC), .TO_CYC(TO_CYC)) u_clamp (
        .clk_i(clk), .rst_i(rst), .run_i(run), .e_inp_o(e0), .d_inp_i(d_inp),
        .right_i(right), .left_i(left), .rst_cmd_i(rst_cmd), .pos_o(pos0),
        .moved_o(mv0), .bump_o(bp0), .timeout_o(to0));

    move_ctrl #(.POS_W(POS_W), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT), .WRAP(1),
                .TICK_CYC(TICK_CYC), .TO_CYC(TO_CYC)) u_wrap (
        .clk_i(clk), .rst_i(rst), .run_i(run), .e_inp_o(e1), .d_inp_i(d_inp),
        .right_i(right), .left_i(left), .rst_cmd_i(rst_cmd), .pos_o(pos1),
        .moved_o(mv1), .bump_o(bp1), .timeout_o(to1));

    int total = 0;
    int bad   = 0;
    int mpos0 = POS_INIT;
    int mpos1 = POS_INIT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Spec rule as plain arithmetic: signed step, then fold back into range.
    function automatic void model(input int pos, input bit r, input bit l, input bit c,
                                  input bit w, output int np, output bit bmp);
        int delta;
        int t;
        bmp = 1'b0;
        if (c) begin
            np = POS_INIT;
            return;
        end
        delta = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        t = pos + delta;
        if (t > POS_MAX) begin
            t   = w ? 0 : POS_MAX;
            bmp = !w;
        end else if (t < 0) begin
            t   = w ? POS_MAX : 0;
            bmp = !w;
        end
        np = t;
    endfunction

    task automatic wait_req();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (e0 === 1'b1) ok = 1'b1;
            else step();
        end
        chk("req_rise", ok, 1);
        chk("req_match", e1, e0);
    endtask

    task automatic do_move(input bit r, input bit l, input bit c, input int dly, input bit drop_run);
        int np0, np1;
        bit b0, b1;
        wait_req();
        for (int k = 0; k < dly; k++) begin
            run = 1'($urandom_range(0, 1));
            step();
            chk("req_hold0", e0, 1);
            chk("req_hold1", e1, 1);
        end
        run = 1'b1; d_inp = 1'b1; right = r; left = l; rst_cmd = c;
        step();
        d_inp = 1'b0;
        {right, left, rst_cmd} = 3'($urandom);
        if (drop_run) run = 1'b0;
        chk("req_drop0", e0, 0);
        chk("req_drop1", e1, 0);
        chk("pos_pre0", pos0, mpos0);
        chk("pos_pre1", pos1, mpos1);
        chk("moved_pre0", mv0, 0);
        model(mpos0, r, l, c, 1'b0, np0, b0);
        model(mpos1, r, l, c, 1'b1, np1, b1);
        step();
        chk("pos0", pos0, np0);
        chk("pos1", pos1, np1);
        chk("moved0", mv0, (np0 != mpos0));
        chk("moved1", mv1, (np1 != mpos1));
        chk("bump0", bp0, b0);
        chk("bump1", bp1, 0);
        chk("tmo0", to0, 0);
        mpos0 = np0;
        mpos1 = np1;
        step();
        chk("moved_clr0", mv0, 0);
        chk("moved_clr1", mv1, 0);
        chk("bump_clr0", bp0, 0);
        chk("req_low", e0, 0);
        for (int i = 3; i <= TICK_CYC + 1; i++) begin
            step();
            chk("rearm0", e0, (i == TICK_CYC + 1) && !drop_run);
            chk("rearm1", e1, (i == TICK_CYC + 1) && !drop_run);
        end
        if (drop_run) begin
            repeat (3) begin
                step();
                chk("idle_req", e0, 0);
            end
            run = 1'b1;
            step();
            chk("idle_rearm0", e0, 1);
            chk("idle_rearm1", e1, 1);
        end
    endtask

    task automatic do_timeout();
        wait_req();
        run = 1'b1; d_inp = 1'b0;
        for (int i = 1; i <= TO_CYC; i++) begin
            step();
            chk("to_req0", e0, (i < TO_CYC));
            chk("to_req1", e1, (i < TO_CYC));
            chk("to_pulse0", to0, (i == TO_CYC));
            chk("to_pulse1", to1, (i == TO_CYC));
        end
        chk("to_pos0", pos0, mpos0);
        chk("to_pos1", pos1, mpos1);
        step();
        chk("to_clr0", to0, 0);
        chk("to_clr1", to1, 0);
    endtask

    task automatic do_mid_reset();
        wait_req();
        run = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("mrst_req0", e0, 0);
        chk("mrst_req1", e1, 0);
        chk("mrst_pos0", pos0, POS_INIT);
        chk("mrst_pos1", pos1, POS_INIT);
        mpos0 = POS_INIT;
        mpos1 = POS_INIT;
        rst = 1'b1;
        step();
        chk("mrst_rearm", e0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r, l, c;
        int sel;
        rst = 1'b0; run = 1'b0; d_inp = 1'b0; right = 1'b0; left = 1'b0; rst_cmd = 1'b0;
        step();
        step();
        chk("rst_pos0", pos0, POS_INIT);
        chk("rst_pos1", pos1, POS_INIT);
        chk("rst_req", e0, 0);
        chk("rst_pulses", {mv0, bp0, to0, mv1, bp1, to1}, 0);
        rst = 1'b1;
        step();
        chk("idle_stay", e0, 0);
        run = 1'b1;
        step();
        chk("first_req", e0, 1);

        // walk to the top bound and beyond, then to the bottom and beyond
        repeat (10) do_move(1, 0, 0, $urandom_range(0, 4), 0);
        repeat (18) do_move(0, 1, 0, $urandom_range(0, 4), 0);
        do_move(1, 1, 0, 1, 0);
        do_move(0, 0, 0, 2, 0);
        repeat (3) do_move(1, 0, 0, 0, 0);
        do_move(1, 0, 1, 1, 0);
        do_move(1, 0, 1, 0, 0);
        do_timeout();
        do_move(0, 1, 0, 0, 1);
        do_mid_reset();

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                do_timeout();
            end else if (sel == 1) begin
                do_mid_reset();
            end else begin
                sel = $urandom_range(0, 9);
                r = (sel < 4) || (sel == 8);
                l = (sel >= 4 && sel < 8) || (sel == 8);
                c = (sel == 9);
                if (c) {r, l} = 2'($urandom);
                do_move(r, l, c, $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
